reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
- Writer-side counterpart of reg_file: collects destination-register writebacks from the ALU path and the load path and drives reg_file's single write port (write_enable/write_reg/write_data).
- Buffers up to DEPTH pending writes in arrival order so two producers can retire in the same cycle.
- Provides two bypass lookups so decode sees values still queued and not yet committed to reg_file.

Parameters:
DEPTH, 4, pending-write queue entries (power of two, >=2)
XLEN, 32, data width
REG_AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle when alu_valid=1
alu_rd  in  REG_AW  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle when mem_valid=1
mem_rd  in  REG_AW  load destination register
mem_data  in  XLEN  load data
wb_hold  in  1  inhibit draining (write port borrowed elsewhere)
write_enable  out  1  to reg_file write_enable
write_reg  out  REG_AW  to reg_file write_reg
write_data  out  XLEN  to reg_file write_data
lookup1_reg  in  REG_AW  bypass query 1 (rs1)
lookup2_reg  in  REG_AW  bypass query 2 (rs2)
fwd1_hit  out  1  queued write to lookup1_reg exists
fwd1_data  out  XLEN  value of youngest matching entry
fwd2_hit  out  1  as fwd1 for lookup2_reg
fwd2_data  out  XLEN  as fwd1 for lookup2_reg
pending_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer of {rd, data}; head/tail pointers plus count. Reset clears pointers/count; entry contents are don't-care.
- Reset values: write_enable=0, alu_ready=0, mem_ready=0, fwd*_hit=0, pending_count=0. Write and forward data outputs are don't-care while their qualifier is 0.
- Drain (combinational from head):
  - write_enable = (count!=0) && !wb_hold.
  - write_reg/write_data = head entry.
  - Head pops at the edge where write_enable=1; reg_file commits at that same edge.
- Free slots: free = DEPTH - count + (write_enable ? 1 : 0). This includes the slot vacated by this cycle's pop.
- Handshake:
  - alu_ready = (free>=1).
  - mem_ready = (free >= 1 + need_alu), where need_alu = alu_valid && alu_ready && alu_rd!=0.
  - Both ready flags are independent of their own valid.
- Enqueue order: when both fire in one cycle, the ALU entry is written at tail and the load entry at tail+1, so the ALU entry is older. Pointers wrap modulo DEPTH.
- x0: a fired request with rd==0 completes the handshake but is not stored and consumes no slot.
- Latency: request accepted at edge N into an empty queue with wb_hold=0 gives write_enable=1 during cycle N+1; the reg_file value is updated at edge N+1.
- Bypass:
  - fwdK_hit = 1 iff lookupK_reg!=0 and some occupied entry has rd==lookupK_reg. The head entry counts even while it is being written this cycle.
  - fwdK_data comes from the youngest matching entry.
  - Same-cycle incoming requests are not visible to bypass.
- Full with wb_hold=1: free=0, so both ready flags are 0. Held requests must keep valid and payload stable (producer rule; the bench asserts it).
- Full with pop: free=1, so alu_ready=1. mem_ready=1 only if the ALU slot is not needed.
- Reset asserted mid-operation: queue contents are discarded immediately (asynchronous) and write_enable drops to 0 at once.
- pending_count = count, registered.
- Overflow/underflow cannot occur by construction. Implementation includes assertions count<=DEPTH and no pop when empty.

Decomposition:
- Package cpu_pkg: XLEN, REG_AW, typedef wb_entry_t {logic[REG_AW-1:0] rd; logic[XLEN-1:0] data;}. The reg_file write-port signal widths come from the same package.
- One natural sub-module: wb_fwd_match, a youngest-match priority search over the entry array given head and count. Instantiated twice, once per lookup port.

Test Plan:
- Single write: alu_valid rd=1 data=AAAAAAAA, mem idle -> next cycle write_enable=1, write_reg=1, write_data=AAAAAAAA; reg_file x1 reads AAAAAAAA afterwards; pending_count returns to 0.
- Dual retire: alu rd=8 FFFFFFFF and mem rd=3 12345678 in the same cycle -> both ready; reg_file writes x8 in cycle N+1, then x3 in cycle N+2.
- x0 drop: alu rd=0 data=CCCCCCCC -> alu_ready=1, write_enable never asserts, pending_count stays 0, reg_file x0 still reads 0.
- Backpressure: wb_hold=1 with 4 ALU writes to rd=5..8 -> pending_count=4, alu_ready=0. Then a mem request arrives and wb_hold drops to 0 -> drains in order x5..x8, mem_ready rises in the first pop cycle, load is written fifth.
- Bypass youngest: hold and queue rd=2 0x11 then rd=2 0x22, lookup1_reg=2, lookup2_reg=0 -> fwd1_hit=1, fwd1_data=0x22, fwd2_hit=0. After the first pop, fwd1_data is still 0x22.
- Reset mid-drain: 3 entries queued, rst_n low for one cycle -> write_enable=0 immediately, pending_count=0, no further reg_file writes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the writeback queue entry layout.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the occupied part of the writeback queue.
module wb_fwd_match
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [AW-1:0]     head,
  input  logic [CW-1:0]     count,
  input  logic [REG_AW-1:0] lookup_reg,
  output logic              hit,
  output logic [XLEN-1:0]   data
);

  // Walk oldest to youngest so the last match seen wins; x0 never hits.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (lookup_reg != '0) &&
          (entries[AW'(head + AW'(i))].rd == lookup_reg)) begin
        hit  = 1'b1;
        data = entries[AW'(head + AW'(i))].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Merges ALU and load writebacks into one ordered queue feeding the reg_file write port.
module reg_writeback_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_hold,
  output logic              write_enable,
  output logic [REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]   write_data,
  input  logic [REG_AW-1:0] lookup1_reg,
  input  logic [REG_AW-1:0] lookup2_reg,
  output logic              fwd1_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd2_data,
  output logic [CW-1:0]     pending_count
);

  wb_entry_t     entries_q [DEPTH];
  wb_entry_t     entries_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   free_slots;
  logic          need_alu;
  logic          alu_store;
  logic          mem_store;
  logic [AW-1:0] slot;

  // Drain the head entry whenever something is queued and the port is not borrowed.
  always_comb begin
    write_enable = (count_q != '0) && !wb_hold;
    write_reg    = entries_q[head_q].rd;
    write_data   = entries_q[head_q].data;
  end

  // Free slots count the one vacated by this cycle's pop; ALU gets first claim on them.
  always_comb begin
    free_slots = (CW + 1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, write_enable};
    alu_ready  = rst_n && (free_slots != '0);
    need_alu   = alu_valid && alu_ready && (alu_rd != '0);
    mem_ready  = rst_n && (free_slots > {{CW{1'b0}}, need_alu});
  end

  // Enqueue ALU before load so the ALU entry is older; x0 requests are dropped.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    alu_store = alu_valid && alu_ready && (alu_rd != '0);
    mem_store = mem_valid && mem_ready && (mem_rd != '0);
    slot      = tail_q;
    if (alu_store) begin
      entries_d[slot] = {alu_rd, alu_data};
      slot            = slot + 1'b1;
    end
    if (mem_store) begin
      entries_d[slot] = {mem_rd, mem_data};
      slot            = slot + 1'b1;
    end
    tail_d = slot;
    if (write_enable) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + CW'(alu_store) + CW'(mem_store) - CW'(write_enable);
  end

  // Pointer and occupancy state; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign pending_count = count_q;

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries    (entries_q),
    .head       (head_q),
    .count      (count_q),
    .lookup_reg (lookup1_reg),
    .hit        (fwd1_hit),
    .data       (fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries    (entries_q),
    .head       (head_q),
    .count      (count_q),
    .lookup_reg (lookup2_reg),
    .hit        (fwd2_hit),
    .data       (fwd2_data)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(DEPTH));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
    write_enable |-> (count_q != '0));

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue with a reg_file model on the write port.
module tb_reg_writeback_queue;
  import cpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              wb_hold;
  logic              write_enable;
  logic [REG_AW-1:0] write_reg;
  logic [XLEN-1:0]   write_data;
  logic [REG_AW-1:0] lookup1_reg;
  logic [REG_AW-1:0] lookup2_reg;
  logic              fwd1_hit;
  logic [XLEN-1:0]   fwd1_data;
  logic              fwd2_hit;
  logic [XLEN-1:0]   fwd2_data;
  logic [2:0]        pending_count;

  int checkCount = 0;
  int errorCount = 0;

  wb_entry_t        sb[$];
  wb_entry_t        monEntry;
  logic [XLEN-1:0]  regs [32];
  logic             memHeldPrev = 1'b0;
  logic             aluHeldPrev = 1'b0;
  logic [37:0]      memPayloadPrev = '0;
  logic [37:0]      aluPayloadPrev = '0;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .wb_hold       (wb_hold),
    .write_enable  (write_enable),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .lookup1_reg   (lookup1_reg),
    .lookup2_reg   (lookup2_reg),
    .fwd1_hit      (fwd1_hit),
    .fwd1_data     (fwd1_data),
    .fwd2_hit      (fwd2_hit),
    .fwd2_data     (fwd2_data),
    .pending_count (pending_count)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one request cycle, check the handshake, and record expected writebacks.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md,
                               input logic expAlu, input logic expMem);
    wb_entry_t e;
    @(negedge clk);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    #1;
    checkOutput("alu_ready", alu_ready, expAlu);
    checkOutput("mem_ready", mem_ready, expMem);
    if (av && expAlu && ar != 0) begin
      e = {ar, ad};
      sb.push_back(e);
    end
    if (mv && expMem && mr != 0) begin
      e = {mr, md};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the queue to empty; an expired bound is a failed check.
  task automatic waitDrain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (pending_count == 0) break;
      afterEdge();
    end
    checkOutput(tag, pending_count, 0);
  endtask

  // Sample the write port late in each cycle: pop the scoreboard, update the reg_file model,
  // and confirm held requests keep a stable payload.
  always @(negedge clk) begin
    #3;
    if (memHeldPrev) checkOutput("mem_hold_stable", {mem_valid, mem_rd, mem_data}, memPayloadPrev);
    if (aluHeldPrev) checkOutput("alu_hold_stable", {alu_valid, alu_rd, alu_data}, aluPayloadPrev);
    memHeldPrev    = mem_valid && !mem_ready;
    aluHeldPrev    = alu_valid && !alu_ready;
    memPayloadPrev = {mem_valid, mem_rd, mem_data};
    aluPayloadPrev = {alu_valid, alu_rd, alu_data};
    if (write_enable) begin
      checkOutput("wb_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        monEntry = sb.pop_front();
        checkOutput("wb_reg", write_reg, monEntry.rd);
        checkOutput("wb_data", write_data, monEntry.data);
      end
      if (write_reg != 0) regs[write_reg] = write_data;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst_n = 1'b0; wb_hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    lookup1_reg = 5'd1; lookup2_reg = 5'd2;

    // Reset state
    #12;
    checkOutput("rst_write_enable", write_enable, 0);
    checkOutput("rst_alu_ready", alu_ready, 0);
    checkOutput("rst_mem_ready", mem_ready, 0);
    checkOutput("rst_fwd1_hit", fwd1_hit, 0);
    checkOutput("rst_fwd2_hit", fwd2_hit, 0);
    checkOutput("rst_pending", pending_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lookup1_reg = '0; lookup2_reg = '0;
    #1;
    checkOutput("post_rst_alu_ready", alu_ready, 1);

    // Single write with one-cycle latency
    applyStimulus(1, 5'd1, 32'hAAAAAAAA, 0, 5'd0, 32'h0, 1, 1);
    checkOutput("single_we", write_enable, 1);
    checkOutput("single_reg", write_reg, 1);
    checkOutput("single_data", write_data, 32'hAAAAAAAA);
    checkOutput("single_pending", pending_count, 1);
    afterEdge();
    checkOutput("single_pending_after", pending_count, 0);
    checkOutput("single_x1", regs[1], 32'hAAAAAAAA);

    // Dual retire: ALU entry drains first
    applyStimulus(1, 5'd8, 32'hFFFFFFFF, 1, 5'd3, 32'h12345678, 1, 1);
    checkOutput("dual_pending", pending_count, 2);
    checkOutput("dual_first_reg", write_reg, 8);
    afterEdge();
    checkOutput("dual_second_reg", write_reg, 3);
    checkOutput("dual_second_data", write_data, 32'h12345678);
    afterEdge();
    checkOutput("dual_done_we", write_enable, 0);

    // x0 request handshakes but is never stored
    applyStimulus(1, 5'd0, 32'hCCCCCCCC, 0, 5'd0, 32'h0, 1, 1);
    checkOutput("x0_we", write_enable, 0);
    checkOutput("x0_pending", pending_count, 0);
    afterEdge();
    checkOutput("x0_we_later", write_enable, 0);

    // Backpressure: fill while held, then a load waits for the first pop
    @(negedge clk);
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'(5 + i), 32'h50 + 32'(i), 0, 5'd0, 32'h0, 1, (i < 3) ? 1'b1 : 1'b0);
    checkOutput("full_pending", pending_count, 4);
    checkOutput("full_alu_ready", alu_ready, 0);
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99999999;
    #1;
    checkOutput("full_held_mem_ready", mem_ready, 0);
    checkOutput("full_held_we", write_enable, 0);
    @(negedge clk);
    wb_hold = 1'b0;
    #1;
    checkOutput("full_pop_mem_ready", mem_ready, 1);
    checkOutput("full_pop_alu_ready", alu_ready, 1);
    checkOutput("full_pop_reg", write_reg, 5);
    sb.push_back({5'd9, 32'h99999999});
    afterEdge();
    mem_valid = 1'b0;
    waitDrain("backpressure_drain");
    checkOutput("backpressure_x9", regs[9], 32'h99999999);

    // Bypass returns the youngest matching entry
    @(negedge clk);
    wb_hold = 1'b1;
    applyStimulus(1, 5'd2, 32'h11, 0, 5'd0, 32'h0, 1, 1);
    applyStimulus(1, 5'd2, 32'h22, 0, 5'd0, 32'h0, 1, 1);
    lookup1_reg = 5'd2; lookup2_reg = 5'd0;
    #1;
    checkOutput("byp_fwd1_hit", fwd1_hit, 1);
    checkOutput("byp_fwd1_data", fwd1_data, 32'h22);
    checkOutput("byp_fwd2_hit", fwd2_hit, 0);
    @(negedge clk);
    wb_hold = 1'b0;
    #1;
    checkOutput("byp_pop_we", write_enable, 1);
    checkOutput("byp_pop_data", write_data, 32'h11);
    checkOutput("byp_pop_fwd1_data", fwd1_data, 32'h22);
    afterEdge();
    checkOutput("byp_after_hit", fwd1_hit, 1);
    checkOutput("byp_after_data", fwd1_data, 32'h22);
    waitDrain("byp_drain");
    checkOutput("byp_empty_hit", fwd1_hit, 0);

    // Same-cycle pair to one register: the load entry is the younger one
    @(negedge clk);
    wb_hold = 1'b1;
    applyStimulus(1, 5'd4, 32'h44, 1, 5'd4, 32'h55, 1, 1);
    lookup2_reg = 5'd4;
    #1;
    checkOutput("pair_fwd2_hit", fwd2_hit, 1);
    checkOutput("pair_fwd2_data", fwd2_data, 32'h55);
    checkOutput("pair_fwd1_hit", fwd1_hit, 0);
    @(negedge clk);
    wb_hold = 1'b0;
    waitDrain("pair_drain");
    checkOutput("pair_x4", regs[4], 32'h55);

    // Reset in the middle of a drain discards the rest
    @(negedge clk);
    wb_hold = 1'b1;
    applyStimulus(1, 5'd10, 32'hA0, 0, 5'd0, 32'h0, 1, 1);
    applyStimulus(1, 5'd11, 32'hB0, 0, 5'd0, 32'h0, 1, 1);
    applyStimulus(1, 5'd12, 32'hC0, 0, 5'd0, 32'h0, 1, 1);
    @(negedge clk);
    wb_hold = 1'b0;
    #1;
    checkOutput("mid_we", write_enable, 1);
    checkOutput("mid_reg", write_reg, 10);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_we", write_enable, 0);
    checkOutput("mid_rst_pending", pending_count, 0);
    checkOutput("mid_rst_alu_ready", alu_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) afterEdge();
    checkOutput("mid_post_pending", pending_count, 0);
    checkOutput("mid_post_x10", regs[10], 32'hA0);
    checkOutput("mid_post_x11", regs[11], 32'h0);

    afterEdge();
    checkOutput("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
